// File: rtl/alu_pkg.sv
// Shared op-code map, FSM state encoding and op classification for alu_mdu.
package alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_NOR   = 4'd5;
  localparam logic [3:0] OP_SLT   = 4'd6;
  localparam logic [3:0] OP_SLTU  = 4'd7;
  localparam logic [3:0] OP_SLL   = 4'd8;
  localparam logic [3:0] OP_SRL   = 4'd9;
  localparam logic [3:0] OP_SRA   = 4'd10;
  localparam logic [3:0] OP_MUL   = 4'd11;
  localparam logic [3:0] OP_MULHU = 4'd12;
  localparam logic [3:0] OP_DIVU  = 4'd13;
  localparam logic [3:0] OP_REMU  = 4'd14;
  localparam logic [3:0] OP_RSVD  = 4'd15;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } alu_state_e;

  function automatic logic is_multicycle(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned engine: shift-add multiply or restoring divide, one bit per clock.
// MUL leaves the product in {hi,lo}; DIV leaves the quotient in lo and the remainder in hi.
module alu_muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0]   m_q;
  logic               div_q;
  logic               run_q;
  logic [CW-1:0]      cnt_q;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     rem_sub;
  logic               rem_ge;

  always_comb begin
    mul_sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, m_q} : '0);
    // Restoring step: shift the next dividend bit into the partial remainder.
    rem_sh  = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
    rem_ge  = (rem_sh >= {1'b0, m_q});
    rem_sub = rem_sh - {1'b0, m_q};
    if (div_q) begin
      p_d = {(rem_ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0]), p_q[WIDTH-2:0], rem_ge};
    end else begin
      p_d = {mul_sum, p_q[WIDTH-1:1]};
    end
  end

  // High during the edge that performs the final iteration.
  assign done = run_q && (cnt_q == CW'(WIDTH - 1));
  assign lo   = p_q[WIDTH-1:0];
  assign hi   = p_q[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_q   <= '0;
      m_q   <= '0;
      div_q <= 1'b0;
      run_q <= 1'b0;
      cnt_q <= '0;
    end else if (start) begin
      p_q   <= {{WIDTH{1'b0}}, (is_div ? a : b)};
      m_q   <= is_div ? b : a;
      div_q <= is_div;
      run_q <= 1'b1;
      cnt_q <= '0;
    end else if (run_q) begin
      p_q   <= p_d;
      cnt_q <= cnt_q + CW'(1);
      if (done) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// Registered execute-stage ALU with an iterative multiply/divide unit behind a valid/ready handshake.
// Handshake: a request transfers when in_valid && in_ready at a rising edge; out_valid pulses one cycle per result.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             busy,
  output logic [1:0]       dbg_state_o
);

  alu_state_e       state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic             start;
  logic [WIDTH-1:0] sum, diff;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] sc_res;
  logic             sc_ovf;
  logic             eng_done;
  logic [WIDTH-1:0] eng_lo, eng_hi;
  logic [WIDTH-1:0] mc_res;

  assign in_ready    = (state_q == S_IDLE);
  assign busy        = !in_ready;
  assign accept      = in_valid && in_ready;
  assign start       = accept && is_multicycle(op);
  assign sum         = a + b;
  assign diff        = a - b;
  assign shamt       = b[SHW-1:0];
  assign dbg_state_o = state_q;

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .is_div (is_div_op(op)),
    .a      (a),
    .b      (b),
    .done   (eng_done),
    .lo     (eng_lo),
    .hi     (eng_hi)
  );

  always_comb begin
    sc_res = '0;
    sc_ovf = 1'b0;
    case (op)
      OP_ADD: begin
        sc_res = sum;
        sc_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = diff;
        sc_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  sc_res = a & b;
      OP_OR:   sc_res = a | b;
      OP_XOR:  sc_res = a ^ b;
      OP_NOR:  sc_res = ~(a | b);
      // Mixed signs decide directly; equal signs cannot overflow the subtraction.
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}},
                         (a[WIDTH-1] != b[WIDTH-1]) ? a[WIDTH-1] : diff[WIDTH-1]};
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLL:  sc_res = a << shamt;
      OP_SRL:  sc_res = a >> shamt;
      OP_SRA:  sc_res = $unsigned($signed(a) >>> shamt);
      default: sc_res = '0;
    endcase
  end

  assign mc_res = ((op_q == OP_MUL) || (op_q == OP_DIVU)) ? eng_lo : eng_hi;

  always_comb begin
    state_d     = state_q;
    op_d        = start ? op : op_q;
    out_valid_d = 1'b0;
    result_d    = result_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = is_div_op(op) ? S_DIV : S_MUL;
        end else if (accept) begin
          out_valid_d = 1'b1;
          result_d    = sc_res;
          zero_d      = (sc_res == '0);
          ovf_d       = sc_ovf;
        end
      end
      S_MUL, S_DIV: begin
        if (eng_done) state_d = S_DONE;
      end
      S_DONE: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b1;
        result_d    = mc_res;
        zero_d      = (mc_res == '0);
        ovf_d       = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= OP_ADD;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu: a 32-bit and an 8-bit instance with result scoreboards.
module tb_alu_mdu;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // 32-bit instance
  logic        in_valid_32 = 1'b0;
  logic [3:0]  op_32 = 4'd0;
  logic [31:0] a_32 = '0, b_32 = '0;
  logic        in_ready_32, out_valid_32, zero_32, ovf_32, busy_32;
  logic [31:0] result_32;
  logic [1:0]  dbg_32;

  // 8-bit instance
  logic        in_valid_8 = 1'b0;
  logic [3:0]  op_8 = 4'd0;
  logic [7:0]  a_8 = '0, b_8 = '0;
  logic        in_ready_8, out_valid_8, zero_8, ovf_8, busy_8;
  logic [7:0]  result_8;
  logic [1:0]  dbg_8;

  logic [33:0] exp_q[$];
  logic [9:0]  exp8_q[$];

  alu_mdu #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_32), .in_ready(in_ready_32),
    .op(op_32), .a(a_32), .b(b_32), .out_valid(out_valid_32), .result(result_32),
    .zero(zero_32), .overflow(ovf_32), .busy(busy_32), .dbg_state_o(dbg_32)
  );

  alu_mdu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_8), .in_ready(in_ready_8),
    .op(op_8), .a(a_8), .b(b_8), .out_valid(out_valid_8), .result(result_8),
    .zero(zero_8), .overflow(ovf_8), .busy(busy_8), .dbg_state_o(dbg_8)
  );

  // Reference model, packed as {overflow, zero, result}.
  function automatic logic [33:0] model32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        v;
    logic [63:0] p;
    r = '0;
    v = 1'b0;
    p = {32'd0, a} * {32'd0, b};
    case (op)
      4'd0:  begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
      4'd1:  begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = ~(a | b);
      4'd6:  r = {31'd0, ($signed(a) < $signed(b))};
      4'd7:  r = {31'd0, (a < b)};
      4'd8:  r = a << b[4:0];
      4'd9:  r = a >> b[4:0];
      4'd10: r = $unsigned($signed(a) >>> b[4:0]);
      4'd11: r = p[31:0];
      4'd12: r = p[63:32];
      4'd13: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd14: r = (b == 0) ? a : a % b;
      default: r = '0;
    endcase
    return {v, (r == 32'd0), r};
  endfunction

  always @(negedge clk) begin
    if (out_valid_32) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb32_unexpected: out_valid with result=%h, nothing expected", result_32);
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        if ({ovf_32, zero_32, result_32} !== e) begin
          n_err++;
          $display("FAIL sb32_result: got ovf=%b zero=%b res=%h, expected ovf=%b zero=%b res=%h",
                   ovf_32, zero_32, result_32, e[33], e[32], e[31:0]);
        end
      end
    end
    if (out_valid_8) begin
      n_cmp++;
      if (exp8_q.size() == 0) begin
        n_err++;
        $display("FAIL sb8_unexpected: out_valid with result=%h, nothing expected", result_8);
      end else begin
        logic [9:0] e8;
        e8 = exp8_q.pop_front();
        if ({ovf_8, zero_8, result_8} !== e8) begin
          n_err++;
          $display("FAIL sb8_result: got ovf=%b zero=%b res=%h, expected ovf=%b zero=%b res=%h",
                   ovf_8, zero_8, result_8, e8[9], e8[8], e8[7:0]);
        end
      end
    end
  end

  task automatic send32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [33:0] exp);
    int t;
    @(negedge clk);
    in_valid_32 = 1'b1;
    op_32 = op; a_32 = a; b_32 = b;
    exp_q.push_back(exp);
    t = 0;
    while (in_ready_32 !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      n_cmp++; n_err++;
      $display("FAIL send32_timeout: in_ready=%b, expected 1 within 100 cycles", in_ready_32);
    end
    @(posedge clk);
    #1 in_valid_32 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({out_valid_32, result_32, zero_32, ovf_32, in_ready_32, busy_32, dbg_32} !==
        {1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0}) begin
      n_err++;
      $display("FAIL reset32: got ov=%b res=%h z=%b ovf=%b rdy=%b busy=%b st=%0d, expected 0 0 1 0 1 0 0",
               out_valid_32, result_32, zero_32, ovf_32, in_ready_32, busy_32, dbg_32);
    end
    n_cmp++;
    if ({out_valid_8, result_8, zero_8, ovf_8, in_ready_8, busy_8} !== {1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL reset8: got ov=%b res=%h z=%b ovf=%b rdy=%b busy=%b, expected 0 0 1 0 1 0",
               out_valid_8, result_8, zero_8, ovf_8, in_ready_8, busy_8);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ops [3];
    logic [31:0] as  [3];
    logic [31:0] bs  [3];
    logic [33:0] es  [3];
    ops = '{OP_ADD, OP_SUB, OP_SLT};
    as  = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000};
    bs  = '{32'h1, 32'h1, 32'h1};
    es  = '{{1'b1, 1'b0, 32'h8000_0000}, {1'b1, 1'b0, 32'h7FFF_FFFF}, {1'b0, 1'b0, 32'h1}};
    @(negedge clk);
    in_valid_32 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      op_32 = ops[i]; a_32 = as[i]; b_32 = bs[i];
      exp_q.push_back(es[i]);
      @(posedge clk);
      #1;
      if (i == 2) in_valid_32 = 1'b0;
      n_cmp++;
      if (out_valid_32 !== 1'b1 || in_ready_32 !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_pulse%0d: out_valid=%b in_ready=%b, expected 1 1", i, out_valid_32, in_ready_32);
      end
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid_32 !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_idle: out_valid=%b, expected 0", out_valid_32);
    end
  endtask

  task automatic test_single_cycle();
    send32(OP_SLTU, 32'h8000_0000, 32'h1,          {1'b0, 1'b1, 32'h0});
    send32(OP_SRA,  32'h8000_0000, 32'h21,         {1'b0, 1'b0, 32'hC000_0000});
    send32(OP_SLL,  32'h1,         32'd31,         {1'b0, 1'b0, 32'h8000_0000});
    send32(OP_SRL,  32'h8000_0000, 32'h4,          {1'b0, 1'b0, 32'h0800_0000});
    send32(OP_XOR,  32'hFF00_FF00, 32'h0FF0_0FF0,  {1'b0, 1'b0, 32'hF0F0_F0F0});
    send32(OP_OR,   32'h1234_0000, 32'h0000_5678,  {1'b0, 1'b0, 32'h1234_5678});
    send32(OP_NOR,  32'hFFFF_0000, 32'h0000_00FF,  {1'b0, 1'b0, 32'h0000_FF00});
    send32(OP_SLT,  32'h1,         32'h8000_0000,  {1'b0, 1'b1, 32'h0});
    send32(OP_SLT,  32'hFFFF_FFFE, 32'hFFFF_FFFF,  {1'b0, 1'b0, 32'h1});
    send32(OP_SUB,  32'h5,         32'h5,          {1'b0, 1'b1, 32'h0});
    send32(OP_ADD,  32'h8000_0000, 32'h8000_0000,  {1'b1, 1'b1, 32'h0});
    send32(OP_RSVD, 32'h1234_5678, 32'h9ABC_DEF0,  {1'b0, 1'b1, 32'h0});
  endtask

  task automatic test_multi32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] exp_res);
    int lat;
    logic bad_ready;
    @(negedge clk);
    n_cmp++;
    if (in_ready_32 !== 1'b1) begin
      n_err++;
      $display("FAIL multi32_ready_pre: in_ready=%b, expected 1", in_ready_32);
    end
    in_valid_32 = 1'b1;
    op_32 = op; a_32 = a; b_32 = b;
    exp_q.push_back({1'b0, (exp_res == 32'd0), exp_res});
    @(posedge clk);
    #1;
    in_valid_32 = 1'b0;
    a_32 = $urandom; b_32 = $urandom;
    lat = 0;
    bad_ready = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      if (i >= 5 && i <= 10) begin
        in_valid_32 = 1'b1;
        op_32 = OP_ADD;
      end else begin
        in_valid_32 = 1'b0;
      end
      @(posedge clk);
      #1;
      if (out_valid_32) begin
        lat = i;
        break;
      end
      if (in_ready_32 !== 1'b0 || busy_32 !== 1'b1) bad_ready = 1'b1;
    end
    in_valid_32 = 1'b0;
    n_cmp++;
    if (lat != 33) begin
      n_err++;
      $display("FAIL multi32_latency op=%0d: got %0d edges, expected 33", op, lat);
    end
    n_cmp++;
    if (bad_ready !== 1'b0 || in_ready_32 !== 1'b1) begin
      n_err++;
      $display("FAIL multi32_ready op=%0d: busy-window violation=%b, in_ready at result=%b, expected 0 1",
               op, bad_ready, in_ready_32);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid_32 !== 1'b0) begin
      n_err++;
      $display("FAIL multi32_single_pulse op=%0d: out_valid=%b, expected 0", op, out_valid_32);
    end
  endtask

  task automatic test_multi8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] exp_res);
    int lat;
    @(negedge clk);
    in_valid_8 = 1'b1;
    op_8 = op; a_8 = a; b_8 = b;
    exp8_q.push_back({1'b0, (exp_res == 8'd0), exp_res});
    @(posedge clk);
    #1;
    in_valid_8 = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (out_valid_8) begin
        lat = i;
        break;
      end
    end
    n_cmp++;
    if (lat != 9) begin
      n_err++;
      $display("FAIL multi8_latency op=%0d: got %0d edges, expected 9", op, lat);
    end
  endtask

  task automatic test_reset_abort();
    int seen;
    @(negedge clk);
    in_valid_32 = 1'b1;
    op_32 = OP_DIVU; a_32 = 32'd100; b_32 = 32'd7;
    @(posedge clk);
    #1 in_valid_32 = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    n_cmp++;
    if ({out_valid_32, result_32, zero_32, in_ready_32} !== {1'b0, 32'd0, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL abort_state: ov=%b res=%h zero=%b rdy=%b, expected 0 0 1 1",
               out_valid_32, result_32, zero_32, in_ready_32);
    end
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid_32) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_err++;
      $display("FAIL abort_no_result: got %0d out_valid pulses, expected 0", seen);
    end
    @(negedge clk);
    in_valid_32 = 1'b1;
    op_32 = OP_AND; a_32 = 32'h0000_F0F0; b_32 = 32'h0000_0FF0;
    exp_q.push_back({1'b0, 1'b0, 32'h0000_00F0});
    @(posedge clk);
    #1 in_valid_32 = 1'b0;
    n_cmp++;
    if (out_valid_32 !== 1'b1) begin
      n_err++;
      $display("FAIL abort_then_and: out_valid=%b, expected 1 one edge after accept", out_valid_32);
    end
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 30; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 40));
        default: b = $urandom;
      endcase
      send32(op, a, b, model32(op, a, b));
    end
  endtask

  task automatic test_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || exp8_q.size() != 0) && t < 200) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0 || exp8_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d/%0d results outstanding, expected 0/0", exp_q.size(), exp8_q.size());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_single_cycle();
    test_multi32(OP_MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    test_multi32(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    test_multi32(OP_DIVU,  32'd100,       32'd7,         32'd14);
    test_multi32(OP_REMU,  32'd100,       32'd7,         32'd2);
    test_multi32(OP_DIVU,  32'd5,         32'd0,         32'hFFFF_FFFF);
    test_multi32(OP_REMU,  32'd5,         32'd0,         32'd5);
    test_reset_abort();
    test_multi8(OP_MUL,   8'h10, 8'h10, 8'h00);
    test_multi8(OP_MULHU, 8'h10, 8'h10, 8'h01);
    test_multi8(OP_DIVU,  8'd200, 8'd7, 8'd28);
    test_multi8(OP_REMU,  8'd200, 8'd7, 8'd4);
    test_random();
    test_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
